// File: rtl/align_rdq_pkg.sv
// Shared types and constant helpers for the align_1r1wa read-request queue.
package align_rdq_pkg;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } rdq_state_e;

    localparam int FLUSH_W = 4;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int width_of(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    function automatic int min_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/align_rdq_fifo.sv
// Return-data FIFO: registered storage, explicit pointer wrap so any depth works,
// occupancy count drives empty/full. Head reads as zero while empty.
module align_rdq_fifo
    import align_rdq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FIFODEPTH = 4,
    parameter int BITFIFO   = 2,
    localparam int CNT_W    = width_of(FIFODEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0]   r_mem [FIFODEPTH];
    logic [BITFIFO-1:0] r_wptr;
    logic [BITFIFO-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;

    function automatic logic [BITFIFO-1:0] ptr_inc(input logic [BITFIFO-1:0] p);
        if (p == BITFIFO'(FIFODEPTH - 1)) return '0;
        return p + BITFIFO'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(FIFODEPTH));
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/align_1r1wa_rdq.sv
// Read-request front end and return-data queue for the align_1r1wa RAM wrapper.
// Optional return-protocol checker: define ALIGN_RDQ_CHECK_EN.
module align_1r1wa_rdq
    import align_rdq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BITADDR    = 10,
    parameter int RD_LATENCY = 2,
    parameter int FIFODEPTH  = 4,
    parameter int BITFIFO    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_vld,
    input  logic [BITADDR-1:0] req_adr,
    output logic               req_rdy,
    output logic               ram_read,
    output logic [BITADDR-1:0] ram_rd_adr,
    input  logic               ram_rd_vld,
    input  logic [WIDTH-1:0]   ram_rd_dout,
    output logic               out_vld,
    output logic [WIDTH-1:0]   out_dout,
    input  logic               out_rdy,
    output logic               err
);

    localparam int CNT_W = width_of(FIFODEPTH + 1);

    rdq_state_e         r_state;
    rdq_state_e         w_state_nxt;
    logic [FLUSH_W-1:0] r_flush;
    logic [FLUSH_W-1:0] w_flush_nxt;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_run;
    logic               w_issue;
    logic               w_pop;
    logic               w_rd_ret;
    logic               w_push;
    logic               w_empty;
    logic               w_full;
    logic [CNT_W-1:0]   w_count;

    // The wrapper's return pipeline is not reset, so returns are ignored until
    // RD_LATENCY+1 cycles have passed since reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FLUSH;
            r_flush <= FLUSH_W'(RD_LATENCY);
        end else begin
            r_state <= w_state_nxt;
            r_flush <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush;
        unique case (r_state)
            ST_FLUSH: begin
                if (r_flush == '0) w_state_nxt = ST_RUN;
                else               w_flush_nxt = r_flush - FLUSH_W'(1);
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_FLUSH;
            end
        endcase
    end

    assign w_run      = (r_state == ST_RUN);
    assign req_rdy    = w_run && (r_cnt < CNT_W'(FIFODEPTH));
    assign w_issue    = req_vld && req_rdy;
    assign ram_read   = w_issue;
    assign ram_rd_adr = req_adr;

    assign out_vld  = !w_empty;
    assign w_pop    = out_vld && out_rdy;
    assign w_rd_ret = w_run && ram_rd_vld;
    // Credits make a push into a full, non-popping FIFO impossible; the gate
    // only keeps stored data intact if the wrapper misbehaves.
    assign w_push   = w_rd_ret && (!w_full || w_pop);

    // Credits cover both reads in flight and entries already queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            unique case ({w_issue, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    align_rdq_fifo #(
        .WIDTH     (WIDTH),
        .FIFODEPTH (FIFODEPTH),
        .BITFIFO   (BITFIFO)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (ram_rd_dout),
        .i_pop   (w_pop),
        .o_head  (out_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

`ifdef ALIGN_RDQ_CHECK_EN
    logic [15:0]      r_hist;
    logic [15:0]      w_hist_now;
    logic [CNT_W-1:0] r_outst;
    logic             r_err;
    logic             w_err_none;
    logic             w_err_full;
    logic             w_err_order;
    logic             w_chk_fail;

    // Bit k of w_hist_now is the issue from k cycles ago (bit 0 = this cycle).
    assign w_hist_now  = {r_hist[14:0], w_issue};
    assign w_err_none  = w_rd_ret && (r_outst == '0);
    assign w_err_full  = w_rd_ret && (w_count == CNT_W'(FIFODEPTH));
    assign w_err_order = w_run && (w_hist_now[RD_LATENCY] != ram_rd_vld);
    assign w_chk_fail  = w_err_none || w_err_full || w_err_order;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist  <= '0;
            r_outst <= '0;
            r_err   <= 1'b0;
        end else begin
            r_hist <= w_hist_now;
            unique case ({w_issue, w_rd_ret})
                2'b10:   r_outst <= r_outst + CNT_W'(1);
                2'b01:   if (r_outst != '0) r_outst <= r_outst - CNT_W'(1);
                default: r_outst <= r_outst;
            endcase
            if (w_chk_fail) r_err <= 1'b1;
        end
    end

    assign err = r_err;

    a_rd_protocol: assert property (@(posedge clk) disable iff (rst) !w_chk_fail)
        else $error("align_1r1wa_rdq: read return protocol violation");
`else
    logic w_unused_count;
    assign w_unused_count = ^w_count;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_align_1r1wa_rdq.sv
// Bench for align_1r1wa_rdq: fixed-latency wrapper model, queue-based reference
// model checked every cycle, directed scenarios plus a randomized phase.
module tb_align_1r1wa_rdq;

    localparam int W  = 32;
    localparam int AW = 10;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_vld = 1'b0;
    logic [AW-1:0] req_adr = '0;
    logic          req_rdy;
    logic          ram_read;
    logic [AW-1:0] ram_rd_adr;
    logic          ram_rd_vld = 1'b0;
    logic [W-1:0]  ram_rd_dout = '0;
    logic          out_vld;
    logic [W-1:0]  out_dout;
    logic          out_rdy = 1'b0;
    logic          err;

    align_1r1wa_rdq #(
        .WIDTH(W), .BITADDR(AW), .RD_LATENCY(L), .FIFODEPTH(D), .BITFIFO(BF)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_adr(req_adr), .req_rdy(req_rdy),
        .ram_read(ram_read), .ram_rd_adr(ram_rd_adr),
        .ram_rd_vld(ram_rd_vld), .ram_rd_dout(ram_rd_dout),
        .out_vld(out_vld), .out_dout(out_dout), .out_rdy(out_rdy),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] d;
    } ret_t;

    logic [31:0] mem [1024];
    ret_t        pend[$];
    int          gcyc = 0;
    bit          inj = 1'b0;
    logic [31:0] inj_data = '0;

    // Reference model state
    int          m_cyc = 0;
    int          m_cnt = 0;
    logic [31:0] m_q[$];
    bit          m_hist[$];
    bit          m_err = 1'b0;

    logic          s_req_rdy, s_ram_read, s_out_vld, s_err;
    logic [AW-1:0] s_adr;
    logic [W-1:0]  s_dout;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, gcyc);
        end
    endtask

    // One clock cycle: drive the wrapper return, compare against the model,
    // advance the model and the wrapper.
    task automatic step();
        bit run, e_rdy, e_issue, e_vld, pop, push, exp_ret;
        if (inj) begin
            ram_rd_vld = 1'b1; ram_rd_dout = inj_data; inj = 1'b0;
        end else if (pend.size() > 0 && pend[0].due == gcyc) begin
            ram_rd_vld = 1'b1; ram_rd_dout = pend[0].d; void'(pend.pop_front());
        end else begin
            ram_rd_vld = 1'b0; ram_rd_dout = $urandom;
        end
        #1;
        s_req_rdy = req_rdy; s_ram_read = ram_read; s_adr = ram_rd_adr;
        s_out_vld = out_vld; s_dout = out_dout; s_err = err;
        if (rst) begin
            chk("rst_req_rdy", 32'(s_req_rdy), 0);
            chk("rst_ram_read", 32'(s_ram_read), 0);
            chk("rst_out_vld", 32'(s_out_vld), 0);
            chk("rst_out_dout", s_dout, 0);
            chk("rst_err", 32'(s_err), 0);
            m_cyc = 0; m_cnt = 0; m_q.delete(); m_hist.delete(); m_err = 1'b0;
        end else begin
            run     = (m_cyc >= L + 1);
            e_rdy   = run && (m_cnt < D);
            e_issue = req_vld && e_rdy;
            e_vld   = (m_q.size() > 0);
            chk("req_rdy", 32'(s_req_rdy), 32'(e_rdy));
            chk("ram_read", 32'(s_ram_read), 32'(e_issue));
            if (e_issue) chk("ram_rd_adr", 32'(s_adr), 32'(req_adr));
            chk("out_vld", 32'(s_out_vld), 32'(e_vld));
            if (e_vld) chk("out_dout", s_dout, m_q[0]);
            chk("err", 32'(s_err), 32'(m_err));
            pop  = e_vld && out_rdy;
            push = run && ram_rd_vld;
`ifdef ALIGN_RDQ_CHECK_EN
            m_hist.push_back(e_issue);
            if (run) begin
                exp_ret = (m_cyc >= L) ? m_hist[m_cyc - L] : 1'b0;
                if (exp_ret != ram_rd_vld) m_err = 1'b1;
            end
`else
            exp_ret = 1'b0;
`endif
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(ram_rd_dout);
            m_cnt = m_cnt + int'(e_issue) - int'(pop);
            m_cyc++;
        end
        if (s_ram_read === 1'b1) pend.push_back('{gcyc + L, mem[s_adr]});
        @(posedge clk);
        @(negedge clk);
        gcyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nread, nvld, first, last, unstable;
        logic [31:0] held;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[10'h2A5] = 32'hDEADBEEF;

        // Power-on reset, then release with a stale pulse during FLUSH
        rst = 1'b1;
        steps(3);
        rst = 1'b0;
        step();                               chk("rr_rdy_c0", 32'(s_req_rdy), 0);
        inj = 1'b1; inj_data = 32'h0BAD0BAD;
        step();                               chk("rr_rdy_c1", 32'(s_req_rdy), 0);
        step();                               chk("rr_rdy_c2", 32'(s_req_rdy), 0);
        step();                               chk("rr_rdy_c3", 32'(s_req_rdy), 1);
                                              chk("rr_drop_vld", 32'(s_out_vld), 0);
        step();                               chk("rr_drop_vld2", 32'(s_out_vld), 0);

        // Single read, fixed latency
        out_rdy = 1'b1; req_vld = 1'b1; req_adr = 10'h2A5;
        step();
        chk("sr_read", 32'(s_ram_read), 1);
        chk("sr_adr", 32'(s_adr), 32'h2A5);
        req_vld = 1'b0;
        step();                               chk("sr_vld_t1", 32'(s_out_vld), 0);
        step();                               chk("sr_vld_t2", 32'(s_out_vld), 0);
        step();                               chk("sr_vld_t3", 32'(s_out_vld), 1);
                                              chk("sr_dout", s_dout, 32'hDEADBEEF);
        step();                               chk("sr_vld_t4", 32'(s_out_vld), 0);
        chk("sr_model_cnt", 32'(m_cnt), 0);

        // Streaming, no backpressure
        nread = 0; nvld = 0; first = -1; last = -1;
        for (int i = 0; i < 106; i++) begin
            req_vld = (i < 100); req_adr = AW'($urandom);
            step();
            nread += int'(s_ram_read);
            if (s_out_vld) begin
                nvld++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("st_reads", 32'(nread), 100);
        chk("st_outputs", 32'(nvld), 100);
        chk("st_no_bubble", 32'(last - first + 1), 100);

        // Backpressure
        out_rdy = 1'b0; nread = 0; unstable = 0; held = '0; first = -1;
        for (int i = 0; i < 8; i++) begin
            req_vld = 1'b1; req_adr = AW'($urandom);
            step();
            nread += int'(s_ram_read);
            if (s_out_vld) begin
                if (first < 0) begin first = i; held = s_dout; end
                else if (s_dout !== held) unstable++;
            end
        end
        chk("bp_accepted", 32'(nread), 4);
        chk("bp_rdy_low", 32'(s_req_rdy), 0);
        chk("bp_dout_stable", 32'(unstable), 0);
        req_vld = 1'b0; out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        step();                               chk("bp_reopen", 32'(s_req_rdy), 1);
        out_rdy = 1'b1;
        steps(6);

        // Reset with two reads in flight and one queued
        out_rdy = 1'b0;
        req_vld = 1'b1; req_adr = AW'($urandom); step();
        req_vld = 1'b0;                          step();
        req_vld = 1'b1; req_adr = AW'($urandom); step();
        req_adr = AW'($urandom);                 step();
        chk("mr_queued", 32'(s_out_vld), 1);
        rst = 1'b1; req_vld = 1'b0;
        #1;
        chk("mr_async_vld", 32'(out_vld), 0);
        chk("mr_async_rdy", 32'(req_rdy), 0);
        step();
        rst = 1'b0; out_rdy = 1'b1;
        steps(4);
        chk("mr_stale_drop", 32'(s_out_vld), 0);
        chk("mr_err", 32'(s_err), 0);
        steps(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req_vld = ($urandom_range(0, 99) < 60);
            req_adr = AW'($urandom);
            out_rdy = ($urandom_range(0, 99) < 70);
            step();
        end
        req_vld = 1'b0; out_rdy = 1'b1;
        steps(8);

`ifdef ALIGN_RDQ_CHECK_EN
        inj = 1'b1; inj_data = 32'h5A5A5A5A;
        step();
        step();                               chk("ck_err_set", 32'(s_err), 1);
        steps(3);                             chk("ck_err_sticky", 32'(s_err), 1);
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        step();                               chk("ck_err_clear", 32'(s_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/align_1r1wa_rdq.md
Name: align_1r1wa_rdq

Overview:
- Read-request front end and return-data queue for the align_1r1wa RAM wrapper.
- Accepts read requests on a valid/ready handshake and issues them to the wrapper's no-stall read port (read/rd_adr).
- Captures the fixed-latency rd_vld/rd_dout return into a small FIFO and presents it downstream with valid/ready backpressure.
- Credit-based issue guarantees the FIFO never overflows.

Parameters:
- WIDTH, 32, data width; equals wrapper WIDTH.
- BITADDR, 10, read address width; equals wrapper BITADDR.
- RD_LATENCY, 2, wrapper read→rd_vld latency (SRAM_DELAY+FLOPCMD+FLOPMEM+FLOPOUT); legal range 0..15.
- FIFODEPTH, 4, return FIFO entries; must be ≥1; full throughput requires ≥ RD_LATENCY+2.
- BITFIFO, 2, log2(FIFODEPTH); must be ≥1.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous reset, active-high.
- req_vld  input  1  read request valid.
- req_adr  input  BITADDR  read address.
- req_rdy  output  1  request accepted when req_vld && req_rdy.
- ram_read  output  1  to wrapper read.
- ram_rd_adr  output  BITADDR  to wrapper rd_adr.
- ram_rd_vld  input  1  from wrapper rd_vld.
- ram_rd_dout  input  WIDTH  from wrapper rd_dout.
- out_vld  output  1  return data valid.
- out_dout  output  WIDTH  return data.
- out_rdy  input  1  downstream accept.
- err  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset values: req_rdy=0, ram_read=0, out_vld=0, out_dout=0, err=0. Internal state on reset: credit count cnt=0, FIFO empty, FSM in FLUSH with flush counter = RD_LATENCY.
- FSM, FLUSH: req_rdy=0; ram_rd_vld is ignored (the wrapper's return pipeline is not reset). Counter decrements each cycle. Move to RUN in the cycle after the counter reaches 0. With RD_LATENCY=0, enter RUN one cycle after reset deassertion.
- FSM, RUN: req_rdy = (cnt < FIFODEPTH). This is a function of registered state only; there is no combinational path from out_rdy or req_vld.
- Issue: issue = req_vld && req_rdy. ram_read = issue and ram_rd_adr = req_adr, both combinational with zero added latency. ram_rd_adr is don't-care when ram_read=0.
- Credits: cnt counts in-flight reads plus FIFO occupancy.
  - cnt_next = cnt + issue - pop, where pop = out_vld && out_rdy.
  - Simultaneous issue and pop: cnt unchanged.
  - cnt saturates by construction within 0..FIFODEPTH.
- Capture: in RUN, ram_rd_vld=1 writes ram_rd_dout at the FIFO tail. The write is visible on out_vld the next cycle (registered FIFO, no bypass).
  - Push to a full FIFO cannot occur under the credit rule.
  - Simultaneous push and pop is allowed at any occupancy, including full.
- Output: out_vld = FIFO not empty; out_dout = head entry.
  - out_dout is held stable while out_vld && !out_rdy.
  - Data returns in request order.
- Latency: issue at cycle T → out_vld at T+RD_LATENCY+1 (FIFO empty, out_rdy=1). Back-to-back issue is sustained when FIFODEPTH ≥ RD_LATENCY+2.
- Pointers: BITFIFO-bit read/write pointers wrap modulo FIFODEPTH; non-power-of-2 depth is supported by explicit wrap. The full/empty decision uses an occupancy count, not pointer equality.
- Reset mid-operation: in-flight reads and FIFO contents are discarded. The FSM re-enters FLUSH, so stale wrapper returns arriving within RD_LATENCY cycles are dropped.

Optional Feature:
- Macro: ALIGN_RDQ_CHECK_EN.
- Defined: an outstanding counter increments on issue and decrements on ram_rd_vld in RUN. err is set (sticky until rst) on any of:
  - ram_rd_vld with outstanding==0;
  - push while the FIFO is full;
  - ram_rd_vld gap violating fixed RD_LATENCY ordering, i.e. the issue history shift register bit at RD_LATENCY does not match ram_rd_vld.
  Simulation assertions fire on the same conditions.
- Not defined: err tied to 0; no checker logic is synthesized.

Decomposition:
- Shared package align_rdq_pkg holds:
  - FSM state enum (FLUSH, RUN);
  - the clog2-style width helper;
  - the minimum-depth constant function (RD_LATENCY+2).
- One sub-module: align_rdq_fifo, parameterised WIDTH/FIFODEPTH/BITFIFO with push/pop/empty/full/count. The credit logic and FSM stay in the top level.

Test Plan:
- Reset release, RD_LATENCY=2: req_rdy=0 for cycles 0–2 after deassertion, then 1; a ram_rd_vld pulse injected at cycle 1 is dropped and out_vld stays 0.
- Single read, adr=0x2A5, model returns 0xDEADBEEF 2 cycles after ram_read: out_vld rises exactly 3 cycles after issue with out_dout=0xDEADBEEF; cnt returns to 0 after pop.
- Streaming with out_rdy=1, FIFODEPTH=4: 100 back-to-back requests give ram_read high 100 consecutive cycles and 100 in-order outputs with no bubbles.
- Backpressure, out_rdy=0: exactly 4 requests are accepted, then req_rdy=0; raising out_rdy for 1 cycle pops one entry and re-opens req_rdy the next cycle; out_dout stays stable while stalled.
- Reset asserted with 2 reads in flight and 1 queued: out_vld=0 immediately (async); stale returns during FLUSH are ignored; err=0.
- With ALIGN_RDQ_CHECK_EN, a spurious ram_rd_vld in RUN with nothing outstanding sets err=1, which stays 1 until rst.
